rsa_job_seq: RTL and testbench

AHB-lite single-master sequencer that runs one complete RSA-2048 job on the `ahb_rsa2048` slave without CPU involvement. It copies up to 64 operand words from system memory into the accelerator, starts it, polls for completion, then copies the result back to memory. It sits between a job-request source (CPU register block or mailbox) and the AHB fabric, in front of the `ahb_rsa2048` slave port.

---
 rtl/rsa_job_seq.sv | 131 +++++++++++++
 tb/tb_rsa_job_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_seq.sv
// rsa_job_seq: AHB-lite master that loads operands into ahb_rsa2048, starts it, polls STATUS and stores the result.
// Optional STATUS-read timeout is enabled by defining RSA_SEQ_TIMEOUT_EN.
module rsa_job_seq #(
   parameter logic [31:0] RSA_BASE = 32'h7800_0000
`ifdef RSA_SEQ_TIMEOUT_EN
   , parameter logic [15:0] POLL_TIMEOUT = 16'hFFFF
`endif
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [31:0] job_src,
   input  logic [31:0] job_dst,
   input  logic [6:0]  job_nwords,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] M_HADDR,
   output logic [1:0]  M_HTRANS,
   output logic        M_HWRITE,
   output logic [2:0]  M_HSIZE,
   output logic [2:0]  M_HBURST,
   output logic [31:0] M_HWDATA,
   input  logic [31:0] M_HRDATA,
   input  logic        M_HREADY,
   input  logic [1:0]  M_HRESP
);
   typedef enum logic [3:0] {IDLE, LD_RD, LD_WR, START, POLL, ST_RD, ST_WR, DONE, ERR} state_t;
   state_t state, nst;
   logic dph, last, nbus, job_ok;
   logic [31:0] src, dst, naddr;
   logic [6:0] nw, idx, ni;
`ifdef RSA_SEQ_TIMEOUT_EN
   logic [15:0] pcnt;
`endif
   assign job_ready = state == IDLE;
   assign busy = state != IDLE;
   assign M_HSIZE = 3'b010;
   assign M_HBURST = 3'b000;
   assign job_ok = job_nwords != 7'd0 && job_nwords <= 7'd64;
   // Successor of the current bus state and the address of its transfer, used when a data phase completes.
   always_comb begin
      last = idx + 7'd1 == nw;
      nst = state == LD_RD ? LD_WR :
            state == LD_WR ? (last ? START : LD_RD) :
            state == START ? POLL :
            state == POLL  ? (M_HRDATA[0] ? ST_RD : POLL) :
            state == ST_RD ? ST_WR :
            state == ST_WR ? (last ? DONE : ST_RD) : IDLE;
`ifdef RSA_SEQ_TIMEOUT_EN
      if (state == POLL && !M_HRDATA[0] && pcnt + 16'd1 == POLL_TIMEOUT) nst = ERR;
`endif
      ni = (state == LD_WR || state == ST_WR) ? (last ? 7'd0 : idx + 7'd1) : idx;
      naddr = nst == LD_RD ? {src[31:2] + 30'(ni), 2'b00} :
              nst == LD_WR ? RSA_BASE + 32'h100 + {23'd0, ni, 2'b00} :
              nst == START ? RSA_BASE :
              nst == POLL  ? RSA_BASE + 32'h4 :
              nst == ST_RD ? RSA_BASE + 32'h200 + {23'd0, ni, 2'b00} :
                             {dst[31:2] + 30'(ni), 2'b00};
      nbus = nst != DONE && nst != ERR && nst != IDLE;
   end
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state <= IDLE;
         dph <= 1'b0;
         M_HTRANS <= 2'b00;
         M_HADDR <= 32'h0;
         M_HWRITE <= 1'b0;
         M_HWDATA <= 32'h0;
         done <= 1'b0;
         err <= 1'b0;
         src <= 32'h0;
         dst <= 32'h0;
         nw <= 7'd0;
         idx <= 7'd0;
`ifdef RSA_SEQ_TIMEOUT_EN
         pcnt <= 16'd0;
`endif
      end else begin
         done <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: if (job_valid) begin
               src <= job_src;
               dst <= job_dst;
               nw <= job_nwords;
               idx <= 7'd0;
`ifdef RSA_SEQ_TIMEOUT_EN
               pcnt <= 16'd0;
`endif
               if (job_ok) begin
                  state <= LD_RD;
                  M_HTRANS <= 2'b10;
                  M_HADDR <= {job_src[31:2], 2'b00};
                  M_HWRITE <= 1'b0;
               end else begin
                  state <= ERR;
                  err <= 1'b1;
               end
            end
            DONE, ERR: state <= IDLE;
            default: if (!dph) begin
               M_HTRANS <= 2'b00;
               dph <= 1'b1;
            end else if (M_HRESP == 2'b01) begin
               // Abort on the first ERROR cycle; the bus stays IDLE through the second one.
               state <= ERR;
               err <= 1'b1;
               dph <= 1'b0;
            end else if (M_HREADY) begin
               dph <= 1'b0;
               state <= nst;
               idx <= ni;
               done <= nst == DONE;
               err <= nst == ERR;
               if (state == LD_RD || state == ST_RD) M_HWDATA <= M_HRDATA;
               if (nst == START) M_HWDATA <= 32'h1;
               if (nbus) begin
                  M_HTRANS <= 2'b10;
                  M_HADDR <= naddr;
                  M_HWRITE <= nst == LD_WR || nst == START || nst == ST_WR;
               end
`ifdef RSA_SEQ_TIMEOUT_EN
               if (state == POLL) pcnt <= pcnt + 16'd1;
`endif
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rsa_job_seq.sv
// tb_rsa_job_seq: scoreboard bench with an AHB slave model for rsa_job_seq.
module tb_rsa_job_seq;
   localparam logic [31:0] BASE = 32'h7800_0000;
   logic clk = 0, rst = 1, job_valid = 0, job_ready, busy, done, err, hwrite, hready = 1;
   logic [31:0] job_src = 0, job_dst = 0, haddr, hwdata, hrdata = 0;
   logic [6:0] job_nwords = 0;
   logic [1:0] htrans, hresp = 0;
   logic [2:0] hsize, hburst;
   int checks = 0, fails = 0;
   int ws = 0, done_at = 1, err_at = 0, stat_reads = 0, opwr = 0, ign_cnt = 0, cyc;
   logic ign = 0;
   typedef struct {logic w; logic [31:0] a; logic [31:0] d;} xfer_t;
   xfer_t q[$];
   logic [31:0] mem [logic [31:0]];

   rsa_job_seq #(
      .RSA_BASE(BASE)
`ifdef RSA_SEQ_TIMEOUT_EN
      , .POLL_TIMEOUT(16'd4)
`endif
   ) dut (
      .HCLK(clk), .HRESET(rst), .job_valid(job_valid), .job_ready(job_ready),
      .job_src(job_src), .job_dst(job_dst), .job_nwords(job_nwords),
      .busy(busy), .done(done), .err(err),
      .M_HADDR(haddr), .M_HTRANS(htrans), .M_HWRITE(hwrite), .M_HSIZE(hsize),
      .M_HBURST(hburst), .M_HWDATA(hwdata), .M_HRDATA(hrdata), .M_HREADY(hready), .M_HRESP(hresp)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (a == BASE + 32'h4) begin
         stat_reads++;
         return (stat_reads >= done_at) ? 32'h1 : 32'h0;
      end
      return mem.exists(a) ? mem[a] : pat(a);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
      xfer_t x;
      x.w = w;
      x.a = a;
      x.d = d;
      q.push_back(x);
   endtask

   task automatic push_job(input int n, input logic [31:0] s, input logic [31:0] d, input int p);
      for (int i = 0; i < n; i++) begin
         push(1'b0, {s[31:2], 2'b00} + 32'(i * 4), 32'h0);
         push(1'b1, BASE + 32'h100 + 32'(i * 4), pat({s[31:2], 2'b00} + 32'(i * 4)));
      end
      push(1'b1, BASE, 32'h1);
      for (int i = 0; i < p; i++) push(1'b0, BASE + 32'h4, 32'h0);
      for (int i = 0; i < n; i++) begin
         push(1'b0, BASE + 32'h200 + 32'(i * 4), 32'h0);
         push(1'b1, {d[31:2], 2'b00} + 32'(i * 4), pat(BASE + 32'h200 + 32'(i * 4)));
      end
   endtask

   task automatic start(input logic [6:0] n, input logic [31:0] s, input logic [31:0] d);
      for (int k = 0; k < 100 && !job_ready; k++) @(negedge clk);
      stat_reads = 0;
      opwr = 0;
      job_src = s;
      job_dst = d;
      job_nwords = n;
      job_valid = 1;
      @(posedge clk);
      #1 job_valid = 0;
   endtask

   task automatic wait_end(output int c);
      c = 0;
      for (int k = 1; k <= 3000; k++) begin
         @(negedge clk);
         if (done || err) begin
            c = k;
            break;
         end
      end
      chk("job_end", {31'd0, done | err}, 32'd1);
   endtask

   // Slave: samples the bus mid-cycle, updates its responses just after the next rising edge.
   initial begin : slave
      logic [31:0] a, wd, pa;
      logic [1:0] tr;
      logic w, pw, pend, cur_ready, errnow;
      int wleft, eph;
      pend = 0; pw = 0; pa = 0; errnow = 0; eph = 0; wleft = 0;
      forever begin
         @(negedge clk);
         tr = htrans; a = haddr; w = hwrite; wd = hwdata; cur_ready = hready;
         @(posedge clk);
         #1;
         if (rst) begin
            pend = 0; errnow = 0; eph = 0; hready = 1; hresp = 0;
            continue;
         end
         if (pend && cur_ready) begin
            if (pw && !errnow) mem[pa] = wd;
            pend = 0; errnow = 0; eph = 0;
         end
         if (tr == 2'b10) begin
            pend = 1; pa = a; pw = w; wleft = ws; errnow = 0;
            if (w && a >= BASE + 32'h100 && a < BASE + 32'h200) begin
               opwr++;
               errnow = opwr == err_at;
            end
         end
         hresp = 0;
         hready = 1;
         if (pend) begin
            if (errnow) begin
               hresp = 2'b01;
               hready = eph != 0;
               eph++;
            end else if (wleft > 0) begin
               hready = 0;
               wleft--;
            end else if (!pw) hrdata = rd(pa);
         end
      end
   end

   initial begin : monitor
      logic mp, mw;
      logic [31:0] ma;
      xfer_t e;
      mp = 0; mw = 0; ma = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mp = 0;
            continue;
         end
         if (mp && hready) begin
            mp = 0;
            if (hresp == 2'b00) begin
               if (ign && !mw && ma == BASE + 32'h4) ign_cnt++;
               else if (q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_xfer: got transfer to %h write=%0d, required none", ma, mw);
               end else begin
                  e = q.pop_front();
                  chk("xfer_addr", ma, e.a);
                  chk("xfer_write", {31'd0, mw}, {31'd0, e.w});
                  if (mw) chk("xfer_data", hwdata, e.d);
               end
            end
         end
         if (htrans == 2'b10) begin
            mp = 1; ma = haddr; mw = hwrite;
         end
      end
   end

   initial begin
      logic [6:0] bad [2];
      bit found;
      bad[0] = 7'd0;
      bad[1] = 7'd65;
      repeat (3) @(negedge clk);
      chk("rst_htrans", {30'd0, htrans}, 32'd0);
      chk("rst_haddr", haddr, 32'd0);
      chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
      chk("rst_hwdata", hwdata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_ready", {31'd0, job_ready}, 32'd1);
      rst = 0;
      @(negedge clk);
      // Full 64-word job, zero wait states, STATUS done on the third read.
      ws = 0; done_at = 3;
      push_job(64, 32'h1000, 32'h2000, 3);
      start(7'd64, 32'h1000, 32'h2000);
      wait_end(cyc);
      chk("n64_done", {31'd0, done}, 32'd1);
      chk("n64_cycles", cyc, 32'd521);
      @(negedge clk);
      chk("n64_done_pulse", {31'd0, done}, 32'd0);
      chk("n64_busy", {31'd0, busy}, 32'd0);
      chk("n64_q_empty", q.size(), 32'd0);
      // Single word, two wait states, unaligned addresses.
      ws = 2; done_at = 1;
      push_job(1, 32'h3003, 32'h4002, 1);
      start(7'd1, 32'h3003, 32'h4002);
      wait_end(cyc);
      chk("n1ws_done", {31'd0, done}, 32'd1);
      chk("n1ws_cycles", cyc, 32'd25);
      @(negedge clk);
      chk("n1ws_done_pulse", {31'd0, done}, 32'd0);
      chk("n1ws_busy", {31'd0, busy}, 32'd0);
      chk("n1ws_ready", {31'd0, job_ready}, 32'd1);
      chk("n1ws_q_empty", q.size(), 32'd0);
      ws = 0;
      for (int k = 0; k < 2; k++) begin
         start(bad[k], 32'h1000, 32'h2000);
         wait_end(cyc);
         chk("badn_err", {31'd0, err}, 32'd1);
         chk("badn_cycles", cyc, 32'd1);
         repeat (3) @(negedge clk);
         chk("badn_q_empty", q.size(), 32'd0);
      end
      // ERROR response on the fifth operand write.
      err_at = 5;
      for (int i = 0; i < 5; i++) begin
         push(1'b0, 32'h5000 + 32'(i * 4), 32'h0);
         if (i < 4) push(1'b1, BASE + 32'h100 + 32'(i * 4), pat(32'h5000 + 32'(i * 4)));
      end
      start(7'd8, 32'h5000, 32'h6000);
      wait_end(cyc);
      chk("berr_err", {31'd0, err}, 32'd1);
      chk("berr_cycles", cyc, 32'd21);
      @(negedge clk);
      chk("berr_ready", {31'd0, job_ready}, 32'd1);
      repeat (5) @(negedge clk);
      chk("berr_q_empty", q.size(), 32'd0);
      err_at = 0;
      done_at = 1000000;
`ifdef RSA_SEQ_TIMEOUT_EN
      push_job(0, 32'h0, 32'h0, 4);
      q.push_front('{1'b1, BASE + 32'h100, pat(32'hA000)});
      q.push_front('{1'b0, 32'hA000, 32'h0});
      start(7'd1, 32'hA000, 32'hB000);
      wait_end(cyc);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_cycles", cyc, 32'd15);
      repeat (3) @(negedge clk);
      chk("to_q_empty", q.size(), 32'd0);
`else
      ign = 1; ign_cnt = 0;
      push(1'b0, 32'hA000, 32'h0);
      push(1'b1, BASE + 32'h100, pat(32'hA000));
      push(1'b1, BASE, 32'h1);
      start(7'd1, 32'hA000, 32'hB000);
      cyc = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (err) cyc++;
      end
      chk("nto_err_count", cyc, 32'd0);
      chk("nto_busy", {31'd0, busy}, 32'd1);
      chk("nto_polling", {31'd0, ign_cnt >= 400}, 32'd1);
      chk("nto_q_empty", q.size(), 32'd0);
      rst = 1;
      @(negedge clk);
      chk("nto_rst_busy", {31'd0, busy}, 32'd0);
      rst = 0;
      ign = 0;
`endif
      // Reset during ST_RD of a 16-word job, then a normal job.
      done_at = 1;
      push_job(16, 32'h7000, 32'h8000, 1);
      start(7'd16, 32'h7000, 32'h8000);
      found = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (htrans == 2'b10 && haddr == BASE + 32'h20C) begin
            found = 1;
            break;
         end
      end
      chk("mid_found", {31'd0, found}, 32'd1);
      rst = 1;
      @(negedge clk);
      chk("mid_htrans", {30'd0, htrans}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_ready", {31'd0, job_ready}, 32'd1);
      rst = 0;
      q.delete();
      @(negedge clk);
      ws = 1;
      push_job(2, 32'h9000, 32'hA100, 1);
      start(7'd2, 32'h9000, 32'hA100);
      wait_end(cyc);
      chk("post_done", {31'd0, done}, 32'd1);
      chk("post_cycles", cyc, 32'd31);
      @(negedge clk);
      chk("post_q_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
